ag_tcu_fedp_int: RTL and testbench

Integer fused element-wise dot-product unit for the AG tensor core. It is the integer-mode successor of the FP16/BF16 FEDP datapath.
- Consumes N packed 32-bit words per operand per beat, in int8/uint8/int4/uint4.
- Multiplies all lanes and reduces them through a registered adder tree.
- Accumulates across multiple K-beats in an internal 32-bit accumulator seeded from `c_val`, so one dot product can span any number of beats.
- Sits beside the FP FEDP in the TCU execute path, selected by `fmt_s`.

---
 rtl/ag_tcu_pkg.sv | 66 ++++++
 rtl/ag_tcu_fedp_int_lane_mul.sv | 49 ++++
 rtl/ag_tcu_fedp_int.sv | 124 ++++++++++++
 tb/tb_ag_tcu_fedp_int.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ag_tcu_pkg.sv
// Shared constants, stage payload and lane helpers for the AG TCU integer FEDP.
// XLEN_64 selects a 64-bit register width; only the low 32 bits carry data.
package ag_tcu_pkg;

`ifdef XLEN_64
    localparam int unsigned XLEN = 64;
`else
    localparam int unsigned XLEN = 32;
`endif

    localparam logic [2:0] AG_FMT_I8 = 3'd3;
    localparam logic [2:0] AG_FMT_U8 = 3'd4;
    localparam logic [2:0] AG_FMT_I4 = 3'd5;
    localparam logic [2:0] AG_FMT_U4 = 3'd6;

    localparam int unsigned AG_WORD_W    = 32;
    localparam int unsigned AG_LANES_W8  = 4;
    localparam int unsigned AG_LANES_W4  = 8;
    localparam int unsigned AG_LANES_MAX = 8;
    localparam int unsigned AG_LANE_W    = 9;
    localparam int unsigned AG_PROD_W    = 18;
    localparam int unsigned AG_ACC_W     = 32;

    localparam int unsigned AG_FEDP_INT_LATENCY = 4;

    // Per-beat control carried alongside the datapath through S1..S3.
    typedef struct packed {
        logic                valid;
        logic                first;
        logic                last;
        logic [AG_ACC_W-1:0] seed;
    } ag_fedp_ctl_t;

    // Extend one lane to 9-bit signed; unknown formats and idle 8-bit lanes give 0.
    function automatic logic [AG_LANE_W-1:0] ag_lane_ext(
        input logic [2:0]           fmt,
        input logic [AG_WORD_W-1:0] word,
        input int unsigned          lane
    );
        logic [7:0] b8;
        logic [3:0] b4;
        b8 = word[8*(lane % AG_LANES_W8) +: 8];
        b4 = word[4*lane +: 4];
        ag_lane_ext = '0;
        case (fmt)
            AG_FMT_I8: if (lane < AG_LANES_W8) ag_lane_ext = {b8[7], b8};
            AG_FMT_U8: if (lane < AG_LANES_W8) ag_lane_ext = {1'b0, b8};
            AG_FMT_I4: ag_lane_ext = {{5{b4[3]}}, b4};
            AG_FMT_U4: ag_lane_ext = {5'b0, b4};
            default:   ag_lane_ext = '0;
        endcase
    endfunction

    // 9x9 signed multiply; the full product always fits in 18 bits.
    function automatic logic [AG_PROD_W-1:0] ag_lane_mul(
        input logic [AG_LANE_W-1:0] a,
        input logic [AG_LANE_W-1:0] b
    );
        logic signed [AG_PROD_W-1:0] ax;
        logic signed [AG_PROD_W-1:0] bx;
        ax = AG_PROD_W'($signed(a));
        bx = AG_PROD_W'($signed(b));
        ag_lane_mul = ax * bx;
    endfunction

endpackage

// File: rtl/ag_tcu_fedp_int_lane_mul.sv
// One 32-bit word pair: S1 unpack/extend register, S2 lane product register.
module ag_tcu_int_lane_mul
    import ag_tcu_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [2:0]                          fmt,
    input  logic [AG_WORD_W-1:0]                a_word,
    input  logic [AG_WORD_W-1:0]                b_word,
    output logic [AG_LANES_MAX*AG_PROD_W-1:0]   prod
);

    logic [AG_LANES_MAX*AG_LANE_W-1:0] a_ext_c;
    logic [AG_LANES_MAX*AG_LANE_W-1:0] b_ext_c;
    logic [AG_LANES_MAX*AG_LANE_W-1:0] a_lane;
    logic [AG_LANES_MAX*AG_LANE_W-1:0] b_lane;
    logic [AG_LANES_MAX*AG_PROD_W-1:0] prod_c;

    always_comb begin
        a_ext_c = '0;
        b_ext_c = '0;
        for (int unsigned j = 0; j < AG_LANES_MAX; j++) begin
            a_ext_c[AG_LANE_W*j +: AG_LANE_W] = ag_lane_ext(fmt, a_word, j);
            b_ext_c[AG_LANE_W*j +: AG_LANE_W] = ag_lane_ext(fmt, b_word, j);
        end
    end

    always_comb begin
        prod_c = '0;
        for (int unsigned j = 0; j < AG_LANES_MAX; j++) begin
            prod_c[AG_PROD_W*j +: AG_PROD_W] =
                ag_lane_mul(a_lane[AG_LANE_W*j +: AG_LANE_W], b_lane[AG_LANE_W*j +: AG_LANE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_lane <= '0;
            b_lane <= '0;
            prod   <= '0;
        end else if (enable) begin
            a_lane <= a_ext_c;
            b_lane <= b_ext_c;
            prod   <= prod_c;
        end
    end

endmodule

// File: rtl/ag_tcu_fedp_int.sv
// Integer fused dot-product: N word-pair multipliers, registered sum, S4 accumulator.
// AG_TCU_FEDP_SAT_EN makes the accumulate saturate instead of wrapping.
module ag_tcu_fedp_int
    import ag_tcu_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              valid_in,
    input  logic              first_in,
    input  logic              last_in,
    input  logic [2:0]        fmt_s,
    input  logic [N*XLEN-1:0] a_row,
    input  logic [N*XLEN-1:0] b_col,
    input  logic [XLEN-1:0]   c_val,
    output logic              valid_out,
    output logic [XLEN-1:0]   d_val
);

    localparam int unsigned PROD_BUS_W = AG_LANES_MAX * AG_PROD_W;
    localparam int unsigned NUM_PROD   = N * AG_LANES_MAX;

    // LATENCY=0 selects the fixed pipeline depth; anything else is a build error.
    if (!(LATENCY == 0 || LATENCY == AG_FEDP_INT_LATENCY)) begin : g_latency_chk
        $error("ag_tcu_fedp_int: LATENCY must be 0 or 4");
    end

    ag_fedp_ctl_t              ctl_c;
    ag_fedp_ctl_t              ctl_s1;
    ag_fedp_ctl_t              ctl_s2;
    ag_fedp_ctl_t              ctl_s3;
    logic [N*PROD_BUS_W-1:0]   prod_all;
    logic [AG_ACC_W-1:0]       sum_c;
    logic [AG_ACC_W-1:0]       sum_s3;
    logic [AG_ACC_W-1:0]       base_c;
    logic [AG_ACC_W-1:0]       acc_next_c;
    logic [AG_ACC_W-1:0]       acc_q;
    logic [AG_ACC_W-1:0]       d_q;

    for (genvar g = 0; g < N; g++) begin : g_word
        ag_tcu_int_lane_mul u_lane_mul (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .fmt    (fmt_s),
            .a_word (a_row[g*XLEN +: AG_WORD_W]),
            .b_word (b_col[g*XLEN +: AG_WORD_W]),
            .prod   (prod_all[g*PROD_BUS_W +: PROD_BUS_W])
        );
    end

    always_comb begin
        ctl_c       = '0;
        ctl_c.valid = valid_in;
        ctl_c.first = valid_in & first_in;
        ctl_c.last  = valid_in & last_in;
        ctl_c.seed  = c_val[AG_ACC_W-1:0];
    end

    // Product reduction; wraps, though 8N 18-bit terms cannot overflow for N <= 64.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            sum_c = sum_c + AG_ACC_W'($signed(prod_all[AG_PROD_W*i +: AG_PROD_W]));
        end
    end

`ifdef AG_TCU_FEDP_SAT_EN
    logic [AG_ACC_W:0] sum_wide_c;

    always_comb begin
        base_c     = ctl_s3.first ? ctl_s3.seed : acc_q;
        sum_wide_c = {base_c[AG_ACC_W-1], base_c} + {sum_s3[AG_ACC_W-1], sum_s3};
        acc_next_c = sum_wide_c[AG_ACC_W-1:0];
        if (sum_wide_c[AG_ACC_W] != sum_wide_c[AG_ACC_W-1]) begin
            acc_next_c = sum_wide_c[AG_ACC_W] ? {1'b1, {(AG_ACC_W-1){1'b0}}}
                                              : {1'b0, {(AG_ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        base_c     = ctl_s3.first ? ctl_s3.seed : acc_q;
        acc_next_c = base_c + sum_s3;
    end
`endif

    // Control pipeline S1..S3 and the registered sum; lane data lives in the sub-modules.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctl_s1 <= '0;
            ctl_s2 <= '0;
            ctl_s3 <= '0;
            sum_s3 <= '0;
        end else if (enable) begin
            ctl_s1 <= ctl_c;
            ctl_s2 <= ctl_s1;
            ctl_s3 <= ctl_s2;
            sum_s3 <= sum_c;
        end
    end

    // S4: accumulate, publish on last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q     <= '0;
            d_q       <= '0;
            valid_out <= 1'b0;
        end else if (enable) begin
            valid_out <= ctl_s3.last;
            if (ctl_s3.valid) begin
                acc_q <= acc_next_c;
            end
            if (ctl_s3.last) begin
                d_q <= acc_next_c;
            end
        end
    end

    assign d_val = XLEN'(d_q);

endmodule

// File: tb/tb_ag_tcu_fedp_int.sv
// Directed bench for ag_tcu_fedp_int (N=2) with a per-cycle reference model.
module tb_ag_tcu_fedp_int;
    import ag_tcu_pkg::*;

    localparam int RING = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              valid_in;
    logic              first_in;
    logic              last_in;
    logic [2:0]        fmt_s;
    logic [2*XLEN-1:0] a_row;
    logic [2*XLEN-1:0] b_col;
    logic [XLEN-1:0]   c_val;
    logic              valid_out;
    logic [XLEN-1:0]   d_val;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model state
    int          ecnt = 0;
    logic [31:0] macc = '0;
    logic        mv   = 1'b0;
    logic [31:0] md   = '0;
    logic        sched_v [RING];
    logic [31:0] sched_d [RING];

    ag_tcu_fedp_int #(.N(2), .LATENCY(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .valid_in  (valid_in),
        .first_in  (first_in),
        .last_in   (last_in),
        .fmt_s     (fmt_s),
        .a_row     (a_row),
        .b_col     (b_col),
        .c_val     (c_val),
        .valid_out (valid_out),
        .d_val     (d_val)
    );

    always #5 clk = ~clk;

    // Dot product of one beat from the lane rules, in plain integers.
    function automatic longint model_s(input logic [2:0] f, input logic [2*XLEN-1:0] a,
                                       input logic [2*XLEN-1:0] b);
        longint      s;
        logic [31:0] aw;
        logic [31:0] bw;
        int          av;
        int          bv;
        int          nl;
        int          wb;
        s = 0;
        if (f == 3'd3 || f == 3'd4) begin
            nl = 4; wb = 8;
        end else if (f == 3'd5 || f == 3'd6) begin
            nl = 8; wb = 4;
        end else begin
            return 0;
        end
        for (int w = 0; w < 2; w++) begin
            aw = a[w*XLEN +: 32];
            bw = b[w*XLEN +: 32];
            for (int j = 0; j < nl; j++) begin
                av = int'((aw >> (j*wb)) & ((32'd1 << wb) - 32'd1));
                bv = int'((bw >> (j*wb)) & ((32'd1 << wb) - 32'd1));
                if ((f == 3'd3 || f == 3'd5) && av >= (1 << (wb-1))) av = av - (1 << wb);
                if ((f == 3'd3 || f == 3'd5) && bv >= (1 << (wb-1))) bv = bv - (1 << wb);
                s = s + longint'(av) * longint'(bv);
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] base, input longint s);
        longint t;
        t = longint'(signed'(base)) + s;
`ifdef AG_TCU_FEDP_SAT_EN
        if (t > 64'sd2147483647)  t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
        return t[31:0];
    endfunction

    // Reference: a last beat taken at enabled edge e is published at enabled edge e+3.
    always @(posedge clk) begin
        if (!reset) begin
            macc = '0;
            mv   = 1'b0;
            md   = '0;
            for (int i = 0; i < RING; i++) sched_v[i] = 1'b0;
        end else if (enable) begin
            ecnt = ecnt + 1;
            mv   = sched_v[ecnt % RING];
            if (mv) md = sched_d[ecnt % RING];
            sched_v[ecnt % RING] = 1'b0;
            if (valid_in) begin
                macc = model_add(first_in ? c_val[31:0] : macc, model_s(fmt_s, a_row, b_col));
                if (last_in) begin
                    sched_v[(ecnt + 3) % RING] = 1'b1;
                    sched_d[(ecnt + 3) % RING] = macc;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            checks = checks + 1;
            if (valid_out !== mv) begin
                errors = errors + 1;
                $display("FAIL cmp_valid_out t=%0t act=%0b exp=%0b", $time, valid_out, mv);
            end
            checks = checks + 1;
            if (d_val !== XLEN'(md)) begin
                errors = errors + 1;
                $display("FAIL cmp_d_val t=%0t act=%h exp=%h", $time, d_val, md);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        valid_in = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic beat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic fi, input logic la);
        fmt_s    = f;
        a_row    = {2{XLEN'(a)}};
        b_col    = {2{XLEN'(b)}};
        c_val    = XLEN'(c);
        valid_in = 1'b1;
        first_in = fi;
        last_in  = la;
        @(negedge clk);
    endtask

    // Wait for the next qualified result; checks value and edges waited.
    task automatic wait_res(input string nm, input logic [31:0] exp, input int exp_n);
        int n;
        idle();
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!(valid_out && enable) && n < 20);
        #1;
        checks = checks + 1;
        if (!valid_out) begin
            errors = errors + 1;
            $display("FAIL %s_timeout act=%0b exp=1", nm, valid_out);
        end
        chk(nm, d_val[31:0], exp);
        chk({nm, "_lat"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        fmt_s  = 3'd3;
        a_row  = '0;
        b_col  = '0;
        c_val  = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_d_val", d_val[31:0], 32'd0);
        reset  = 1'b1;
        chk_on = 1'b1;

        beat(3'd3, 32'h01010101, 32'h02020202, 32'd5, 1'b1, 1'b1);
        wait_res("int8_single", 32'd21, 3);

        beat(3'd3, 32'hFFFFFFFF, 32'h01010101, 32'd0, 1'b1, 1'b1);
        wait_res("int8_neg", 32'hFFFFFFF8, 3);
        beat(3'd4, 32'hFFFFFFFF, 32'h01010101, 32'd0, 1'b1, 1'b1);
        wait_res("uint8", 32'd2040, 3);
        beat(3'd5, 32'h11111111, 32'h77777777, 32'd0, 1'b1, 1'b1);
        wait_res("int4", 32'd112, 3);
        beat(3'd6, 32'hFFFFFFFF, 32'h11111111, 32'd0, 1'b1, 1'b1);
        wait_res("uint4", 32'd240, 3);

        beat(3'd3, 32'h01010101, 32'h02020202, 32'd100, 1'b1, 1'b0);
        beat(3'd3, 32'h01010101, 32'h02020202, 32'd999, 1'b0, 1'b0);
        beat(3'd3, 32'h01010101, 32'h02020202, 32'd999, 1'b0, 1'b1);
        beat(3'd3, 32'h01010101, 32'h02020202, 32'd0,   1'b1, 1'b1);
        wait_res("multi", 32'd148, 2);
        wait_res("follow", 32'd16, 1);

        beat(3'd3, 32'h01010101, 32'h02020202, 32'd5, 1'b1, 1'b1);
        idle();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_res("stall", 32'd21, 3);

        beat(3'd3, 32'h01010101, 32'h02020202, 32'd50, 1'b1, 1'b0);
        idle();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_d_val", d_val[31:0], 32'd0);
        reset = 1'b1;
        beat(3'd3, 32'h01010101, 32'h02020202, 32'd77, 1'b0, 1'b1);
        wait_res("after_rst", 32'd16, 3);

        beat(3'd3, 32'h01010101, 32'h02020202, 32'h7FFFFFF0, 1'b1, 1'b1);
`ifdef AG_TCU_FEDP_SAT_EN
        wait_res("overflow", 32'h7FFFFFFF, 3);
`else
        wait_res("overflow", 32'h80000000, 3);
`endif
        beat(3'd1, 32'h01010101, 32'h02020202, 32'h7FFFFFF0, 1'b1, 1'b1);
        wait_res("bad_fmt", 32'h7FFFFFF0, 3);

        idle();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
